// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command parser.
// Optional build macro used by the parser: CMD_TIMEOUT_EN.
package uart_cmd_pkg;

    // ASCII bytes recognised by the command grammar and sent as responses
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_P    = 8'h50;
    localparam logic [7:0] ASCII_P_LC = 8'h70;
    localparam logic [7:0] ASCII_D    = 8'h44;
    localparam logic [7:0] ASCII_D_LC = 8'h64;
    localparam logic [7:0] ASCII_K    = 8'h4B;
    localparam logic [7:0] ASCII_E    = 8'h45;

    // Parser FSM states
    typedef enum logic [2:0] {
        IDLE,
        HEX1,
        HEX2,
        WAIT_CR,
        DISCARD
    } state_t;

    // Command being assembled: pattern select or display byte
    typedef enum logic {
        PAT,
        DISP
    } cmd_t;

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f'
// map to a 4-bit value with o_Valid high; anything else gives o_Valid low.
module ascii_hex_decode (
    input  logic [7:0] i_Byte,
    output logic [3:0] o_Value,
    output logic       o_Valid
);

    // Digits carry their value in the low nibble; letters A-F/a-f have
    // low nibble 1..6, so adding 9 gives 10..15.
    always_comb begin
        o_Value = 4'd0;
        o_Valid = 1'b0;
        if (i_Byte >= 8'h30 && i_Byte <= 8'h39) begin
            o_Valid = 1'b1;
            o_Value = i_Byte[3:0];
        end else if ((i_Byte >= 8'h41 && i_Byte <= 8'h46) ||
                     (i_Byte >= 8'h61 && i_Byte <= 8'h66)) begin
            o_Valid = 1'b1;
            o_Value = i_Byte[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command parser: accepts "P h CR" (pattern select) and "D h h CR"
// (display byte), commits on a complete command and answers 'K' or 'E'
// to the UART transmitter through a one-deep, latest-wins response slot.
// Optional build macro: CMD_TIMEOUT_EN adds an inter-byte timeout that
// abandons a partial command after CLKS_TIMEOUT-1 idle clocks with a nak.
//
// Handshake: o_TX_DV is a one-cycle strobe, asserted whenever a response
// is pending and i_TX_Active is low; o_TX_Byte is valid with the strobe
// and holds the last sent byte afterwards. Inputs are consumed only in
// cycles where i_RX_DV is high.
import uart_cmd_pkg::*;

module uart_cmd_parser #(
    parameter int CLKS_TIMEOUT = 25000000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    input  logic       i_TX_Active,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte,
    output logic [3:0] o_Pattern,
    output logic [7:0] o_Display_Byte,
    output logic       o_Update,
    output logic [7:0] o_Err_Count
);

    state_t     state;
    state_t     cur_state;
    cmd_t       cmd;
    logic [3:0] nib_hi;
    logic [3:0] nib_lo;
    logic [3:0] hex_value;
    logic       hex_valid;
    logic       is_cr;
    logic       timeout_hit;
    logic       ack_evt;
    logic       nak_evt;
    logic       pend_valid;
    logic [7:0] pend_byte;
    logic [7:0] sent_byte;

    ascii_hex_decode u_hex (
        .i_Byte  (i_RX_Byte),
        .o_Value (hex_value),
        .o_Valid (hex_valid)
    );

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = (CLKS_TIMEOUT > 2) ? $clog2(CLKS_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(CLKS_TIMEOUT - 1);

    logic [TO_W-1:0] idle_cnt;

    // Count idle clocks while a command is partially received
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            idle_cnt <= '0;
        end else if (i_RX_DV || state == IDLE || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end

    assign timeout_hit = (state != IDLE) && (idle_cnt == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // A timeout returns the parser to IDLE in the same cycle, so a byte
    // strobed then is interpreted as the start of a fresh command.
    assign cur_state = timeout_hit ? IDLE : state;
    assign is_cr     = (i_RX_Byte == ASCII_CR);

    // Response events: ack on a completed command, nak on CR in a partial
    // or discarded command, or on timeout.
    always_comb begin
        ack_evt = i_RX_DV && is_cr && (cur_state == WAIT_CR);
        nak_evt = timeout_hit ||
                  (i_RX_DV && is_cr && (cur_state inside {HEX1, HEX2, DISCARD}));
    end

    // Send the pending response as soon as the transmitter is free
    assign o_TX_DV   = pend_valid && !i_TX_Active;
    assign o_TX_Byte = o_TX_DV ? pend_byte : sent_byte;

    // Parser FSM, committed registers, response slot and error counter
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state          <= IDLE;
            cmd            <= PAT;
            nib_hi         <= 4'd0;
            nib_lo         <= 4'd0;
            o_Pattern      <= 4'd0;
            o_Display_Byte <= 8'd0;
            o_Update       <= 1'b0;
            o_Err_Count    <= 8'd0;
            pend_valid     <= 1'b0;
            pend_byte      <= 8'd0;
            sent_byte      <= 8'd0;
        end else begin
            o_Update <= 1'b0;

            if (timeout_hit) begin
                state <= IDLE;
            end

            if (i_RX_DV) begin
                case (cur_state)
                    IDLE: begin
                        if (i_RX_Byte == ASCII_P || i_RX_Byte == ASCII_P_LC) begin
                            state <= HEX1;
                            cmd   <= PAT;
                        end else if (i_RX_Byte == ASCII_D || i_RX_Byte == ASCII_D_LC) begin
                            state <= HEX1;
                            cmd   <= DISP;
                        end else if (is_cr || i_RX_Byte == ASCII_LF) begin
                            state <= IDLE;
                        end else begin
                            state <= DISCARD;
                        end
                    end
                    HEX1: begin
                        if (hex_valid) begin
                            nib_hi <= hex_value;
                            state  <= (cmd == PAT) ? WAIT_CR : HEX2;
                        end else if (is_cr) begin
                            state <= IDLE;
                        end else begin
                            state <= DISCARD;
                        end
                    end
                    HEX2: begin
                        if (hex_valid) begin
                            nib_lo <= hex_value;
                            state  <= WAIT_CR;
                        end else if (is_cr) begin
                            state <= IDLE;
                        end else begin
                            state <= DISCARD;
                        end
                    end
                    WAIT_CR: begin
                        if (is_cr) begin
                            state    <= IDLE;
                            o_Update <= 1'b1;
                            if (cmd == PAT) begin
                                o_Pattern <= nib_hi;
                            end else begin
                                o_Display_Byte <= {nib_hi, nib_lo};
                            end
                        end else begin
                            state <= DISCARD;
                        end
                    end
                    DISCARD: begin
                        if (is_cr) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // Sending empties the slot; a new response in the same cycle
            // refills it (later assignment wins), and a new response while
            // still full simply replaces the older one.
            if (o_TX_DV) begin
                pend_valid <= 1'b0;
                sent_byte  <= pend_byte;
            end
            if (ack_evt || nak_evt) begin
                pend_valid <= 1'b1;
                pend_byte  <= ack_evt ? ASCII_K : ASCII_E;
            end

            if (nak_evt && o_Err_Count != 8'hFF) begin
                o_Err_Count <= o_Err_Count + 8'd1;
            end
        end
    end

endmodule
